// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: decode-side handshake and execute-side result bus of alu_ctrl_pipe.
interface alu_ctrl_if #(parameter int CTRL_W = 6);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instruction;
  logic [1:0]        alu_op;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] alu_ctrl;
  logic              is_muldiv;
  logic              illegal;
  logic              mdu_busy;
  modport master (
    output in_valid, instruction, alu_op, out_ready,
    input  in_ready, out_valid, alu_ctrl, is_muldiv, illegal, mdu_busy
  );
  modport slave (
    input  in_valid, instruction, alu_op, out_ready,
    output in_ready, out_valid, alu_ctrl, is_muldiv, illegal, mdu_busy
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU/MDU control decoder with valid/ready output and MDU busy countdown.
module alu_ctrl_pipe #(
  parameter int CTRL_W     = 6,
  parameter bit M_EXT      = 1'b1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 34
) (
  input logic       clk,
  input logic       rst_n,
  input logic       flush,
  alu_ctrl_if.slave bus
);
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [4:0] {
    C_NONE = 5'd0, C_ADD = 5'd1, C_SUB = 5'd2, C_AND = 5'd3, C_OR = 5'd4,
    C_XOR = 5'd5, C_SLL = 5'd6, C_SLT = 5'd7, C_SLTU = 5'd8, C_SRL = 5'd9,
    C_SRA = 5'd10, C_MUL = 5'd16
  } code_e;
  function automatic code_e base_op(input logic [2:0] f);
    case (f)
      3'd0:    base_op = C_ADD;
      3'd1:    base_op = C_SLL;
      3'd2:    base_op = C_SLT;
      3'd3:    base_op = C_SLTU;
      3'd4:    base_op = C_XOR;
      3'd5:    base_op = C_SRL;
      3'd6:    base_op = C_OR;
      default: base_op = C_AND;
    endcase
  endfunction
  logic [2:0]    f3;
  logic [6:0]    f7;
  code_e         dec_code;
  logic          dec_ill, dec_md;
  logic          valid_q, valid_d, md_q, md_d, ill_q, ill_d;
  code_e         code_q, code_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy, accept, fire;
  assign f3 = bus.instruction[14:12];
  assign f7 = bus.instruction[31:25];
  always_comb begin
    dec_code = C_NONE;
    dec_ill  = 1'b0;
    dec_md   = 1'b0;
    if (bus.instruction != 32'd0) begin
      case (bus.alu_op)
        2'b00: begin
          dec_code = (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ? C_ADD : C_NONE;
          dec_ill  = (dec_code == C_NONE);
        end
        2'b01: dec_code = C_SUB;
        2'b10: begin
          if (f7 == 7'b0000000) dec_code = base_op(f3);
          else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) dec_code = (f3 == 3'b000) ? C_SUB : C_SRA;
          else if (f7 == 7'b0000001 && M_EXT) begin
            dec_code = code_e'({2'b10, f3});
            dec_md   = 1'b1;
          end else dec_ill = 1'b1;
        end
        default: begin
          // shift-immediates carry funct7 in imm[11:5]; only the RV32I encodings are legal
          if (f3 == 3'b001) dec_ill = (f7 != 7'b0000000);
          else if (f3 == 3'b101) dec_ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
          dec_code = dec_ill ? C_NONE : (f3 == 3'b101 && f7 == 7'b0100000) ? C_SRA : base_op(f3);
        end
      endcase
    end
  end
  assign busy         = (cnt_q != '0);
  assign bus.in_ready = !busy && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign fire         = valid_q && bus.out_ready;
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : fire ? 1'b0 : valid_q;
    code_d  = accept ? dec_code : code_q;
    md_d    = accept ? dec_md : md_q;
    ill_d   = accept ? dec_ill : ill_q;
    // code bit 2 separates the DIV/REM group (20-23) from the MUL group (16-19)
    cnt_d   = (fire && md_q && !ill_q) ? (code_q[2] ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES))
            : busy ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      code_q  <= C_NONE;
      md_q    <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      code_q  <= code_d;
      md_q    <= md_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.out_valid = valid_q;
  assign bus.alu_ctrl  = CTRL_W'(code_q);
  assign bus.is_muldiv = md_q;
  assign bus.illegal   = ill_q;
  assign bus.mdu_busy  = busy;
endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Registered, handshaked successor to the combinational ALU control decoder.
- Decodes instruction plus ALUOp into an ALU/MDU operation code, with optional RV32M support (M_EXT).
- Holds the decoded op in a one-entry output register with valid/ready flow control.
- Stalls issue with an internal countdown while a fixed-latency multiply/divide is in flight. Sits between the decode stage and the ALU/MDU execute stage.

Parameters:
CTRL_W, 6, width of ctrl code output (>=5)
M_EXT, 1, 1 = decode RV32M ops, 0 = funct7 0000001 is illegal
MUL_CYCLES, 4, busy cycles after a MUL-class op is issued (>=1)
DIV_CYCLES, 34, busy cycles after a DIV/REM-class op is issued (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous: drop held entry
in_valid  in  1  instruction/alu_op valid
in_ready  out  1  block can accept this cycle
instruction  in  32  full instruction word
alu_op  in  2  00 ld/st, 01 branch, 10 R-type, 11 I-type
out_valid  out  1  held entry valid
out_ready  in  1  execute stage accepts
alu_ctrl  out  CTRL_W  decoded op code
is_muldiv  out  1  held op is an MDU op
illegal  out  1  held op failed decode
mdu_busy  out  1  MDU countdown nonzero

Behaviour:
- Codes: NONE=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 SLL=6 SLT=7 SLTU=8 SRL=9 SRA=10 MUL=16 MULH=17 MULHSU=18 MULHU=19 DIV=20 DIVU=21 REM=22 REMU=23; f3=instr[14:12], f7=instr[31:25].
- instruction==0: NONE, illegal=0 (bubble), still occupies the entry.
- alu_op 00: f3 in {000,001,010,100,101} -> ADD, else NONE+illegal.
- alu_op 01: SUB always.
- alu_op 10, f7=0000000: 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
- alu_op 10, f7=0100000: f3 000 -> SUB, f3 101 -> SRA, other f3 illegal.
- alu_op 10, f7=0000001 with M_EXT=1: f3 000..111 -> MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU; is_muldiv=1.
- alu_op 10: any other f7, or f7=0000001 with M_EXT=0 -> NONE+illegal.
- alu_op 11: f3 as R-type with f7 ignored, except f3 001 needs f7=0000000 and f3 101 needs f7 in {0000000 -> SRL, 0100000 -> SRA}; violations -> NONE+illegal. is_muldiv=0.
- Handshake:
  - accept = in_valid && in_ready; fire = out_valid && out_ready.
  - in_ready = !mdu_busy && (!out_valid || out_ready).
  - Latency: accept at edge N -> out_valid, alu_ctrl, is_muldiv, illegal valid after edge N.
  - Outputs stable while out_valid && !out_ready.
  - fire without accept clears out_valid; fire with accept reloads (back-to-back, full throughput).
- MDU countdown:
  - Counter width $clog2(max(MUL_CYCLES,DIV_CYCLES)+1).
  - On fire with is_muldiv: load MUL_CYCLES (codes 16-19) or DIV_CYCLES (20-23).
  - Decrement each cycle while nonzero; mdu_busy = (count != 0). in_ready is low for exactly that many cycles after the fire edge.
  - Illegal entries never load the counter.
- flush: clears out_valid at the next edge and blocks accept that cycle (in_ready still reported; the accept is ignored). Does not touch the counter: an in-flight MDU op completes its busy window.
- Reset (async, rst_n low): out_valid=0, alu_ctrl=0, is_muldiv=0, illegal=0, counter=0, mdu_busy=0. in_ready=1 after reset is released. Reset mid-countdown aborts it immediately.
- Outputs when out_valid=0: alu_ctrl/is_muldiv/illegal hold their last values (don't-care to consumers).

Test Plan:
- Reset, then in_valid with 0x40B50533 (sub), alu_op=10, out_ready=1 -> one cycle later out_valid=1, alu_ctrl=2, illegal=0; next cycle out_valid=0.
- Back-to-back stream of add/xor/sra (0x00B50533, 0x00B54533, 0x40B55533) with out_ready=1 -> in_ready stays 1, outputs 1, 5, 10 on consecutive cycles.
- div 0x02B54533 with DIV_CYCLES=34, then mul queued -> alu_ctrl=20, is_muldiv=1. After fire, mdu_busy=1 and in_ready=0 for exactly 34 cycles. mul accepted on cycle 35 -> alu_ctrl=16.
- Same div with M_EXT=0 -> alu_ctrl=0, illegal=1, is_muldiv=0; no busy window.
- I-type slli with f7=0100000 (0x40151513, alu_op=11) -> illegal=1. srai 0x40155513 -> alu_ctrl=10. instruction=0 -> alu_ctrl=0, illegal=0.
- Backpressure: out_ready=0 for 5 cycles with an entry held -> outputs stable, in_ready=0. flush -> out_valid=0 next cycle. rst_n low during a DIV countdown -> mdu_busy=0 immediately.
